cmp3_bubble_sorter: RTL and testbench

- Sequential sorter that puts N packed 3-bit unsigned values in ascending order.
- Reuses one shared 3-bit magnitude comparator (L/E/G outputs) and applies it to one adjacent pair per clock cycle.
- A bubble-sort FSM drives the comparator. It runs passes, counts swaps and exits early when a pass makes no swap.
- Sits between a register-file style producer and any consumer that needs ordered 3-bit keys.

---
 rtl/cmp3_bubble_sorter_pkg.sv | 13 +
 rtl/comparator_3_bit.sv | 16 +
 rtl/cmp3_bubble_sorter.sv | 131 +++++++++++++
 tb/tb_cmp3_bubble_sorter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cmp3_bubble_sorter_pkg.sv
// Shared widths and state encoding for the 3-bit bubble sorter and its comparator.
package cmp3_bubble_sorter_pkg;

   localparam int ELEM_W = 3;
   localparam int SWP_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/comparator_3_bit.sv
// Purely combinational 3-bit unsigned magnitude comparator with less/equal/greater flags.
module comparator_3_bit
   import cmp3_bubble_sorter_pkg::*;
(
   input  logic [ELEM_W-1:0] a,
   input  logic [ELEM_W-1:0] b,
   output logic              l,
   output logic              e,
   output logic              g
);

   assign l = (a < b);
   assign e = (a == b);
   assign g = (a > b);

endmodule

// File: rtl/cmp3_bubble_sorter.sv
// Bubble sorter for N packed 3-bit keys: one shared comparator, one adjacent pair per cycle,
// early exit on the first pass that makes no swap.
module cmp3_bubble_sorter
   import cmp3_bubble_sorter_pkg::*;
#(
   parameter int N = 4
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ELEM_W*N-1:0]   data_in,
   output logic                  busy,
   output logic                  done,
   output logic [ELEM_W*N-1:0]   data_out,
   output logic [SWP_W-1:0]      swap_count
);

   localparam int               IDX_W = (N > 2) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 2);

   state_t               state;
   logic [ELEM_W-1:0]    arr     [N];
   logic [ELEM_W-1:0]    arr_nxt [N];
   logic [IDX_W-1:0]     pass;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     idx_nxt;
   logic [SWP_W-1:0]     swaps;
   logic [SWP_W-1:0]     swaps_nxt;
   logic                 pass_swapped;
   logic [ELEM_W-1:0]    cmp_a;
   logic [ELEM_W-1:0]    cmp_b;
   logic                 lt;
   logic                 eq;
   logic                 gt;
   logic                 do_swap;
   logic                 pass_end;
   logic                 sort_end;
   logic [ELEM_W*N-1:0]  packed_nxt;

   assign idx_nxt = idx + IDX_W'(1);
   assign cmp_a   = arr[idx];
   assign cmp_b   = arr[idx_nxt];

   comparator_3_bit u_cmp (
      .a (cmp_a),
      .b (cmp_b),
      .l (lt),
      .e (eq),
      .g (gt)
   );

   // Swap only on a strict G so equal keys never move, which keeps the sort stable.
   assign do_swap   = gt & ~(lt | eq);
   assign swaps_nxt = swaps + SWP_W'(do_swap);
   assign pass_end  = ((idx + pass) >= LAST);
   assign sort_end  = ~(pass_swapped | do_swap) | (pass == LAST);

   always_comb begin
      arr_nxt    = arr;
      packed_nxt = '0;
      if (do_swap) begin
         arr_nxt[idx]     = cmp_b;
         arr_nxt[idx_nxt] = cmp_a;
      end
      for (int i = 0; i < N; i++) begin
         packed_nxt[ELEM_W*i +: ELEM_W] = arr_nxt[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         data_out     <= '0;
         swap_count   <= '0;
         pass         <= '0;
         idx          <= '0;
         swaps        <= '0;
         pass_swapped <= 1'b0;
         for (int i = 0; i < N; i++) begin
            arr[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < N; i++) begin
                     arr[i] <= data_in[ELEM_W*i +: ELEM_W];
                  end
                  pass         <= '0;
                  idx          <= '0;
                  swaps        <= '0;
                  pass_swapped <= 1'b0;
                  busy         <= 1'b1;
                  state        <= CMP;
               end
            end
            CMP: begin
               arr          <= arr_nxt;
               swaps        <= swaps_nxt;
               pass_swapped <= pass_swapped | do_swap;
               if (!pass_end) begin
                  idx <= idx_nxt;
               end else if (sort_end) begin
                  // Results are taken from the post-swap array so the last compare counts.
                  data_out   <= packed_nxt;
                  swap_count <= swaps_nxt;
                  done       <= 1'b1;
                  state      <= DONE;
               end else begin
                  pass         <= pass + IDX_W'(1);
                  idx          <= '0;
                  pass_swapped <= 1'b0;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp3_bubble_sorter.sv
// Self-checking bench for cmp3_bubble_sorter (N=4): directed table, restart/reset corner
// cases, and random vectors scored against an inversion-count reference model.
module tb_cmp3_bubble_sorter;

   localparam int N = 4;
   localparam int W = 3 * N;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] data_in;
   logic         busy;
   logic         done;
   logic [W-1:0] data_out;
   logic [3:0]   swap_count;

   int checks = 0;
   int errors = 0;

   cmp3_bubble_sorter #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .data_in    (data_in),
      .busy       (busy),
      .done       (done),
      .data_out   (data_out),
      .swap_count (swap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] din;
      logic [W-1:0] dout;
      int           swaps;
      int           lat;
   } vec_t;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Reference: sorted result by counting, swaps = inversion count, passes from the
   // largest number of greater keys preceding any element (plus one clean pass if room).
   function automatic void model(input logic [W-1:0] din, output logic [W-1:0] dout,
                                 output int swaps, output int comps);
      int v[N];
      int cnt[8];
      int m, g, pos, passes;
      for (int i = 0; i < N; i++) v[i] = int'(din[3*i +: 3]);
      for (int k = 0; k < 8; k++) cnt[k] = 0;
      swaps = 0;
      m = 0;
      for (int i = 0; i < N; i++) begin
         g = 0;
         for (int j = 0; j < i; j++) if (v[j] > v[i]) g++;
         swaps += g;
         if (g > m) m = g;
         cnt[v[i]]++;
      end
      dout = '0;
      pos = 0;
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < cnt[k]; c++) begin
            dout[3*pos +: 3] = 3'(k);
            pos++;
         end
      end
      passes = (m + 1 < N - 1) ? m + 1 : N - 1;
      comps = 0;
      for (int p = 0; p < passes; p++) comps += N - 1 - p;
   endfunction

   // Pulses start with din, then watches 20 sample points (1 time unit after each edge).
   // lat is the sample index at which done is first seen, counted from the start edge.
   task automatic applyStimulus(input logic [W-1:0] din, input bit restart,
                                input logic [W-1:0] alt, output int lat,
                                output int busy_cycles, output int done_pulses);
      @(negedge clk);
      data_in = din;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      data_in     = '0;
      lat         = -1;
      busy_cycles = 0;
      done_pulses = 0;
      for (int s = 0; s < 20; s++) begin
         if (busy) busy_cycles++;
         if (done) begin
            done_pulses++;
            if (lat < 0) lat = s;
         end
         if (restart && s == 2) begin
            start   = 1'b1;
            data_in = alt;
         end
         if (restart && s == 4) start = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   vec_t         vecs[4];
   int           lat, bc, dp;
   logic [W-1:0] exp_out;
   int           exp_swaps, exp_comps;
   bit           saw_done;

   initial begin
      vecs[0] = '{din: 12'h2EF, dout: 12'hF59, swaps: 6, lat: 6};
      vecs[1] = '{din: 12'hF59, dout: 12'hF59, swaps: 0, lat: 3};
      vecs[2] = '{din: 12'h924, dout: 12'h924, swaps: 0, lat: 3};
      vecs[3] = '{din: 12'h2C3, dout: 12'h6C8, swaps: 3, lat: 6};

      rst_n   = 1'b0;
      start   = 1'b0;
      data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_data_out", int'(data_out), 0);
      checkOutput("reset_swap_count", int'(swap_count), 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed table");
      for (int t = 0; t < 4; t++) begin
         applyStimulus(vecs[t].din, 1'b0, '0, lat, bc, dp);
         checkOutput($sformatf("table%0d_data_out", t), int'(data_out), int'(vecs[t].dout));
         checkOutput($sformatf("table%0d_swap_count", t), int'(swap_count), vecs[t].swaps);
         checkOutput($sformatf("table%0d_latency", t), lat, vecs[t].lat);
         checkOutput($sformatf("table%0d_busy_cycles", t), bc, vecs[t].lat + 1);
         checkOutput($sformatf("table%0d_done_pulses", t), dp, 1);
      end

      $display("[TB] start re-asserted during CMP");
      applyStimulus(12'h2EF, 1'b1, 12'h924, lat, bc, dp);
      checkOutput("restart_data_out", int'(data_out), 12'hF59);
      checkOutput("restart_swap_count", int'(swap_count), 6);
      checkOutput("restart_latency", lat, 6);
      checkOutput("restart_done_pulses", dp, 1);

      $display("[TB] reset mid-sort");
      @(negedge clk);
      data_in = 12'h2EF;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_done", int'(done), 0);
      checkOutput("midreset_data_out", int'(data_out), 0);
      checkOutput("midreset_swap_count", int'(swap_count), 0);
      @(negedge clk);
      rst_n    = 1'b1;
      saw_done = 1'b0;
      for (int s = 0; s < 10; s++) begin
         @(posedge clk);
         #1;
         if (done || busy) saw_done = 1'b1;
      end
      checkOutput("midreset_stays_idle", int'(saw_done), 0);
      applyStimulus(12'h2EF, 1'b0, '0, lat, bc, dp);
      checkOutput("after_reset_data_out", int'(data_out), 12'hF59);
      checkOutput("after_reset_swap_count", int'(swap_count), 6);
      checkOutput("after_reset_latency", lat, 6);

      $display("[TB] random vectors");
      for (int r = 0; r < 40; r++) begin
         logic [W-1:0] din;
         din = W'($urandom);
         model(din, exp_out, exp_swaps, exp_comps);
         applyStimulus(din, 1'b0, '0, lat, bc, dp);
         checkOutput($sformatf("rand%0d_data_out", r), int'(data_out), int'(exp_out));
         checkOutput($sformatf("rand%0d_swap_count", r), int'(swap_count), exp_swaps);
         checkOutput($sformatf("rand%0d_latency", r), lat, exp_comps);
         checkOutput($sformatf("rand%0d_done_pulses", r), dp, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
